// File: rtl/pll_reset_sequencer.sv
// Sequencer for the system PLL: pulses its reset, qualifies lock, then releases the
// output-clock domain resets in order. All logic runs on the always-alive reference clock.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int NUM_DOMAINS         = 4,
  parameter int STAGGER_CYCLES      = 8,
  parameter int LOSS_FILTER_CYCLES  = 4
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   sw_relock,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic                   timeout_err,
  output logic [7:0]             relock_count
);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_LOCK_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int RELEASE_CYCLES = NUM_DOMAINS * STAGGER_CYCLES;
  localparam int MAX_COUNT = max2(max2(max2(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES),
                                       max2(LOCK_STABLE_CYCLES, RELEASE_CYCLES)),
                                  LOSS_FILTER_CYCLES);
  localparam int CW = $clog2(MAX_COUNT + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t RST_LAST     = cnt_t'(RST_PULSE_CYCLES - 1);
  localparam cnt_t TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
  localparam cnt_t STABLE_LAST  = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam cnt_t RELEASE_LAST = cnt_t'(RELEASE_CYCLES - 1);
  localparam cnt_t LOSS_LAST    = cnt_t'(LOSS_FILTER_CYCLES - 1);

  state_t                 state, state_next;
  cnt_t                   cnt, cnt_next;
  logic                   sync_meta, locked_s;
  logic                   set_timeout, restart_from_run;
  logic                   pll_rst_next, ready_next;
  logic [NUM_DOMAINS-1:0] domain_rst_next;

  // State, counter, lock synchronizer and registered outputs.
  // NOTE: every flop here uses <= so all state updates see the pre-edge values.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state        <= S_PLL_RST;
      cnt          <= '0;
      sync_meta    <= 1'b0;
      locked_s     <= 1'b0;
      pll_rst      <= 1'b1;
      domain_rst   <= '1;
      ready        <= 1'b0;
      timeout_err  <= 1'b0;
      relock_count <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      sync_meta   <= pll_locked;
      locked_s    <= sync_meta;
      pll_rst     <= pll_rst_next;
      domain_rst  <= domain_rst_next;
      ready       <= ready_next;
      timeout_err <= timeout_err | set_timeout;
      if (restart_from_run && relock_count != 8'hFF)
        relock_count <= relock_count + 8'd1;
    end
  end

  // Next state. In RUN the shared counter tracks consecutive low lock samples.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt + 1'b1;
    set_timeout      = 1'b0;
    restart_from_run = 1'b0;
    unique case (state)
      S_PLL_RST: begin
        if (cnt == RST_LAST) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_next = S_LOCK_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          set_timeout = 1'b1;
          state_next  = S_PLL_RST;
        end
      end
      S_LOCK_STABLE: begin
        if (!locked_s)                state_next = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (!locked_s)                state_next = S_PLL_RST;
        else if (cnt == RELEASE_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        cnt_next = locked_s ? '0 : cnt + 1'b1;
        if (sw_relock || (!locked_s && cnt == LOSS_LAST)) begin
          restart_from_run = 1'b1;
          state_next       = S_PLL_RST;
        end
      end
      default: state_next = S_PLL_RST;
    endcase
    if (state_next != state) cnt_next = '0;
  end

  // Outputs are decoded from the upcoming state so they change on the transition edge.
  always_comb begin
    pll_rst_next    = (state_next == S_PLL_RST);
    ready_next      = (state_next == S_RUN);
    domain_rst_next = '1;
    if (state_next == S_RUN) begin
      domain_rst_next = '0;
    end else if (state_next == S_RELEASE) begin
      for (int k = 0; k < NUM_DOMAINS; k++)
        domain_rst_next[k] = (int'(cnt_next) < k * STAGGER_CYCLES);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a vector table for bring-up, directed corner sequences,
// and a randomized run against a phase/age reference model.
module tb_pll_reset_sequencer;

  localparam int RST_PULSE = 4;
  localparam int TIMEOUT   = 32;
  localparam int STABLE    = 8;
  localparam int ND        = 4;
  localparam int STAGGER   = 2;
  localparam int LOSS      = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          sw_relock = 1'b0;
  logic          pll_rst;
  logic [ND-1:0] domain_rst;
  logic          ready;
  logic          timeout_err;
  logic [7:0]    relock_count;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES   (RST_PULSE),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT),
    .LOCK_STABLE_CYCLES (STABLE),
    .NUM_DOMAINS        (ND),
    .STAGGER_CYCLES     (STAGGER),
    .LOSS_FILTER_CYCLES (LOSS)
  ) dut (
    .refclk      (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .sw_relock   (sw_relock),
    .pll_rst     (pll_rst),
    .domain_rst  (domain_rst),
    .ready       (ready),
    .timeout_err (timeout_err),
    .relock_count(relock_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Reference model: which phase the sequencer is in and how many cycles it has spent there.
  localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_REL = 3, P_RUN = 4;
  int m_phase = P_RST;
  int m_age   = 0;
  int m_low   = 0;
  int m_rc    = 0;
  bit m_terr  = 1'b0;
  bit m_hist[$];

  task automatic enter(input int p);
    m_phase = p;
    m_age   = 0;
    m_low   = 0;
  endtask

  // Called at each rising edge, with inputs stable. Lock seen by the sequencer at an edge
  // is the pll_locked value sampled two edges earlier.
  task automatic model_step();
    bit ls;
    if (rst) begin
      m_hist.delete();
      enter(P_RST);
      m_terr = 1'b0;
      m_rc   = 0;
      return;
    end
    ls = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 1'b0;
    m_hist.push_back(pll_locked);
    if (m_hist.size() > 4) void'(m_hist.pop_front());
    m_age++;
    case (m_phase)
      P_RST:  if (m_age >= RST_PULSE) enter(P_WAIT);
      P_WAIT: begin
        if (ls) enter(P_STAB);
        else if (m_age >= TIMEOUT) begin
          m_terr = 1'b1;
          enter(P_RST);
        end
      end
      P_STAB: begin
        if (!ls) enter(P_WAIT);
        else if (m_age >= STABLE) enter(P_REL);
      end
      P_REL: begin
        if (!ls) enter(P_RST);
        else if (m_age >= ND * STAGGER) enter(P_RUN);
      end
      default: begin
        m_low = ls ? 0 : m_low + 1;
        if (m_low >= LOSS || sw_relock) begin
          if (m_rc < 255) m_rc++;
          enter(P_RST);
        end
      end
    endcase
  endtask

  function automatic int model_vec();
    logic [ND-1:0] d;
    logic [7:0]    rc;
    bit            pr, rd;
    pr = (m_phase == P_RST);
    rd = (m_phase == P_RUN);
    rc = m_rc[7:0];
    d  = '1;
    if (m_phase == P_RUN) d = '0;
    else if (m_phase == P_REL)
      for (int k = 0; k < ND; k++) d[k] = (m_age < k * STAGGER);
    return int'({pr, d, rd, m_terr, rc});
  endfunction

  function automatic int dut_vec();
    return int'({pll_rst, domain_rst, ready, timeout_err, relock_count});
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic pulse_sw();
    sw_relock = 1'b1;
    tick(1);
    sw_relock = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int i;
    for (i = 0; i < budget && !ready; i++) tick(1);
    check(name, int'(ready), 1);
  endtask

  task automatic wait_dom(input string name, input logic [ND-1:0] val, input int budget);
    int i;
    for (i = 0; i < budget && domain_rst != val; i++) tick(1);
    check(name, int'(domain_rst), int'(val));
  endtask

  typedef struct {
    int            hold;
    bit            rst;
    bit            lock;
    bit            exp_pll_rst;
    logic [ND-1:0] exp_dom;
    bit            exp_ready;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int lock_left;

    // Normal bring-up; rows are applied for 'hold' edges and then checked.
    vecs[0]  = '{3, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0};
    vecs[1]  = '{3, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0};
    vecs[2]  = '{1, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0};
    vecs[3]  = '{4, 1'b0, 1'b0, 1'b0, 4'hF, 1'b0};
    vecs[4]  = '{9, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0};
    vecs[5]  = '{1, 1'b0, 1'b1, 1'b0, 4'hF, 1'b0};
    vecs[6]  = '{1, 1'b0, 1'b1, 1'b0, 4'hE, 1'b0};
    vecs[7]  = '{1, 1'b0, 1'b1, 1'b0, 4'hE, 1'b0};
    vecs[8]  = '{1, 1'b0, 1'b1, 1'b0, 4'hC, 1'b0};
    vecs[9]  = '{2, 1'b0, 1'b1, 1'b0, 4'h8, 1'b0};
    vecs[10] = '{2, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0};
    vecs[11] = '{1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0};
    vecs[12] = '{1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1};

    for (int i = 0; i < 13; i++) begin
      rst        = vecs[i].rst;
      pll_locked = vecs[i].lock;
      tick(vecs[i].hold);
      check($sformatf("bringup[%0d].pll_rst", i), int'(pll_rst), int'(vecs[i].exp_pll_rst));
      check($sformatf("bringup[%0d].domain_rst", i), int'(domain_rst), int'(vecs[i].exp_dom));
      check($sformatf("bringup[%0d].ready", i), int'(ready), int'(vecs[i].exp_ready));
      check($sformatf("bringup[%0d].timeout_err", i), int'(timeout_err), 0);
      check($sformatf("bringup[%0d].relock_count", i), int'(relock_count), 0);
    end

    // RUN glitch filter: a 2-cycle dip is ignored, a 3-cycle loss restarts.
    pll_locked = 1'b0;
    tick(2);
    pll_locked = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("glitch_ready_held", int'(ready), 1);
    end
    pll_locked = 1'b0;
    tick(4);
    check("loss_not_yet", int'(ready), 1);
    tick(1);
    check("loss_ready", int'(ready), 0);
    check("loss_domain_rst", int'(domain_rst), 4'hF);
    check("loss_pll_rst", int'(pll_rst), 1);
    check("loss_relock_count", int'(relock_count), 1);
    tick(3);
    check("loss_pulse_high", int'(pll_rst), 1);
    tick(1);
    check("loss_pulse_end", int'(pll_rst), 0);
    pll_locked = 1'b1;
    wait_ready("loss_rebringup", 60);

    // Software relock in RUN, ignored in WAIT_LOCK, coincident with loss.
    pulse_sw();
    pll_locked = 1'b0;
    check("sw_ready", int'(ready), 0);
    check("sw_domain_rst", int'(domain_rst), 4'hF);
    check("sw_relock_count", int'(relock_count), 2);
    tick(4);
    check("sw_wait_entered", int'(pll_rst), 0);
    tick(3);
    pulse_sw();
    check("sw_in_wait_count", int'(relock_count), 2);
    check("sw_in_wait_no_restart", int'(pll_rst), 0);
    pll_locked = 1'b1;
    wait_ready("sw_rebringup", 60);
    check("sw_in_wait_not_queued", int'(relock_count), 2);
    pll_locked = 1'b0;
    tick(4);
    pulse_sw();
    check("coincident_count", int'(relock_count), 3);
    check("coincident_ready", int'(ready), 0);
    pll_locked = 1'b1;
    wait_ready("coincident_rebringup", 60);
    check("coincident_single_inc", int'(relock_count), 3);

    // Lock drop at stable count 5 forces a full requalification.
    pll_locked = 1'b0;
    pulse_sw();
    tick(4);
    check("stab_wait_entered", int'(pll_rst), 0);
    pll_locked = 1'b1;
    tick(6);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(4);
    check("stab_no_early_release", int'(domain_rst), 4'hF);
    tick(6);
    check("stab_still_held", int'(domain_rst), 4'hF);
    tick(1);
    check("stab_release_dom0", int'(domain_rst), 4'hE);
    wait_ready("stab_rebringup", 60);
    check("stab_relock_count", int'(relock_count), 4);

    // Lock timeout with lock held low.
    pll_locked = 1'b0;
    pulse_sw();
    tick(4);
    check("to_wait_pll_rst", int'(pll_rst), 0);
    tick(31);
    check("to_before_err", int'(timeout_err), 0);
    check("to_before_pll_rst", int'(pll_rst), 0);
    tick(1);
    check("to_err_set", int'(timeout_err), 1);
    check("to_pll_rst", int'(pll_rst), 1);
    check("to_domain_rst", int'(domain_rst), 4'hF);
    check("to_no_count", int'(relock_count), 5);
    tick(3);
    check("to_pulse_high", int'(pll_rst), 1);
    tick(1);
    check("to_pulse_end", int'(pll_rst), 0);
    pll_locked = 1'b1;
    wait_ready("to_rebringup", 60);
    check("to_err_sticky", int'(timeout_err), 1);

    // Relock counter saturation.
    for (int i = 0; i < 300; i++) begin
      pulse_sw();
      wait_ready("sat_rebringup", 60);
    end
    check("sat_count", int'(relock_count), 255);
    pulse_sw();
    check("sat_hold", int'(relock_count), 255);

    // Reset mid-RELEASE.
    wait_dom("mid_release_reach", 4'hC, 60);
    rst = 1'b1;
    tick(1);
    check("rst_domain_rst", int'(domain_rst), 4'hF);
    check("rst_pll_rst", int'(pll_rst), 1);
    check("rst_ready", int'(ready), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    check("rst_relock_count", int'(relock_count), 0);
    tick(1);
    rst = 1'b0;

    // Randomized traffic against the reference model.
    lock_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (lock_left == 0) begin
        pll_locked = ~pll_locked;
        if (pll_locked) lock_left = $urandom_range(1, 80);
        else lock_left = ($urandom_range(0, 9) == 0) ? 45 : $urandom_range(1, 6);
      end
      lock_left--;
      sw_relock = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 799) == 0);
      tick(1);
      check($sformatf("rand[%0d]", i), dut_vec(), model_vec());
    end
    sw_relock = 1'b0;
    rst       = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
